// File: rtl/fp32_norm_round_pkg.sv
// Shared constants and beat types for the fp32 normalise + round stage.
// - Input format: signed biased exponent and a 28-bit raw mantissa
//   (carry, hidden, 23-bit fraction, guard, round, sticky).
// - Output format: the exponent and fraction widths that fp32_packer expects.
// - Beat structs: one for each of the two pipeline register banks.
package fp32_norm_round_pkg;

    localparam int EXP_IN_W   = 10;   // signed biased exponent at input
    localparam int MANT_IN_W  = 28;   // raw mantissa incl. carry and G/R/S
    localparam int BIAS       = 127;
    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int FP32_WIDTH = 32;
    localparam int MAX_EXP    = 255;

    // Raw mantissa bit positions
    localparam int RAW_CARRY_BIT  = 27;
    localparam int RAW_HIDDEN_BIT = 26;
    localparam int RAW_FRAC_LSB   = 3;
    localparam int RAW_GUARD_BIT  = 2;
    localparam int RAW_ROUND_BIT  = 1;
    localparam int RAW_STICKY_BIT = 0;

    // Normalised mantissa drops the carry bit: [26] hidden .. [0] sticky
    localparam int NORM_W   = MANT_IN_W - 1;
    // One extra exponent bit so carry-in and cancellation never wrap
    localparam int EXP_WK_W = EXP_IN_W + 1;
    localparam int LZC_W    = 5;

    typedef struct packed {
        logic                sign;
        logic [EXP_WK_W-1:0] exp;
        logic [NORM_W-1:0]   mant;
        logic                zero;
        logic                inf;
        logic                nan;
    } s1_beat_t;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] frac;
        logic                  zero;
        logic                  inf;
        logic                  nan;
    } s2_beat_t;

endpackage

// File: rtl/fp32_norm_round_lzc.sv
// 27-bit leading-zero counter, purely combinational.
// Ports:
//   din  in  27  value to scan, MSB first
//   lz   out 5   number of leading zeros (27 when din is zero)
module fp32_norm_round_lzc
    import fp32_norm_round_pkg::*;
(
    input  logic [NORM_W-1:0] din,
    output logic [LZC_W-1:0]  lz
);

    // hit is one-hot: bit gi marks the most significant set bit of din.
    logic [NORM_W-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NORM_W; gi++) begin : g_hit
            if (gi == NORM_W - 1) begin : g_top
                assign hit[gi] = din[gi];
            end else begin : g_low
                assign hit[gi] = din[gi] & ~(|din[NORM_W-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        lz = LZC_W'(NORM_W);
        for (int i = 0; i < NORM_W; i++) begin
            if (hit[i]) begin
                lz = LZC_W'(NORM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_norm_round.sv
// Two-stage normalise + round-to-nearest-even between the alignment/add stage
// and fp32_packer. Stage 1 normalises the raw sum; stage 2 rounds and
// classifies into nan/inf/zero/normal. Subnormal results flush to signed zero.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake
//   in_sign, in_exp, in_mant unnormalised sum (exp is signed, biased, refers to bit 26)
//   in_is_nan, in_is_inf     upstream special-case flags
//   out_valid / out_ready    output handshake
//   final_sign/exponent/mantissa, result_is_zero/inf/nan   to fp32_packer
module fp32_norm_round
    import fp32_norm_round_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_IN_W-1:0]   in_exp,
    input  logic [MANT_IN_W-1:0]  in_mant,
    input  logic                  in_is_nan,
    input  logic                  in_is_inf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  final_sign,
    output logic [EXP_WIDTH-1:0]  final_exponent,
    output logic [MANT_WIDTH-1:0] final_mantissa,
    output logic                  result_is_zero,
    output logic                  result_is_inf,
    output logic                  result_is_nan
);

    localparam logic signed [EXP_WK_W-1:0] MAX_EXP_W = EXP_WK_W'(MAX_EXP);

    logic     s1_valid_q, s1_valid_d;
    logic     s2_valid_q, s2_valid_d;
    s1_beat_t s1_q, s1_d;
    s2_beat_t s2_q, s2_d;

    logic s1_adv, s2_adv;

    // ---------------- handshake ----------------
    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // ---------------- stage 1: normalise ----------------
    logic [LZC_W-1:0]    lz;
    logic [EXP_WK_W-1:0] in_exp_ext;
    logic [EXP_WK_W-1:0] norm_exp;
    logic [NORM_W-1:0]   norm_mant;
    logic                norm_zero;

    fp32_norm_round_lzc u_lzc (
        .din (in_mant[NORM_W-1:0]),
        .lz  (lz)
    );

    assign in_exp_ext = {in_exp[EXP_IN_W-1], in_exp};

    always_comb begin
        norm_zero = (in_mant == '0);
        if (in_mant[RAW_CARRY_BIT]) begin
            // Carry set: shift right by one, folding the dropped bit into sticky.
            norm_mant = {in_mant[MANT_IN_W-1:2], in_mant[1] | in_mant[0]};
            norm_exp  = in_exp_ext + EXP_WK_W'(1);
        end else begin
            norm_mant = in_mant[NORM_W-1:0] << lz;
            norm_exp  = in_exp_ext - EXP_WK_W'(lz);
        end
        // A zero mantissa carries no meaningful exponent; park it at 0 so the
        // overflow test in stage 2 can never turn an exact zero into inf.
        if (norm_zero) begin
            norm_exp = '0;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.sign = in_sign;
                s1_d.exp  = norm_exp;
                s1_d.mant = norm_mant;
                s1_d.zero = norm_zero;
                s1_d.inf  = in_is_inf;
                s1_d.nan  = in_is_nan;
            end
        end
    end

    // ---------------- stage 2: round + classify ----------------
    logic                  rnd_lsb, rnd_g, rnd_r, rnd_s, rnd_up;
    logic [MANT_WIDTH:0]   frac_sum;
    logic                  rnd_carry;
    logic [EXP_WK_W-1:0]   rnd_exp;
    s2_beat_t              s2_res;

    always_comb begin
        rnd_lsb  = s1_q.mant[RAW_FRAC_LSB];
        rnd_g    = s1_q.mant[RAW_GUARD_BIT];
        rnd_r    = s1_q.mant[RAW_ROUND_BIT];
        rnd_s    = s1_q.mant[RAW_STICKY_BIT];
        rnd_up   = rnd_g & (rnd_r | rnd_s | rnd_lsb);
        frac_sum = {1'b0, s1_q.mant[RAW_HIDDEN_BIT-1:RAW_FRAC_LSB]} + (MANT_WIDTH+1)'(rnd_up);
        // A fraction overflow ripples through the hidden bit; the fraction
        // bits left in frac_sum are already zero in that case.
        rnd_carry = frac_sum[MANT_WIDTH] & s1_q.mant[RAW_HIDDEN_BIT];
        rnd_exp   = s1_q.exp + EXP_WK_W'(rnd_carry);

        s2_res      = '0;
        s2_res.sign = s1_q.sign;
        if (s1_q.nan) begin
            s2_res.nan = 1'b1;
        end else if (s1_q.inf || ($signed(rnd_exp) >= MAX_EXP_W)) begin
            s2_res.inf = 1'b1;
            s2_res.exp = EXP_WIDTH'(MAX_EXP);
        end else if (s1_q.zero || ($signed(rnd_exp) <= $signed(EXP_WK_W'(0)))) begin
            s2_res.zero = 1'b1;
        end else begin
            s2_res.exp  = rnd_exp[EXP_WIDTH-1:0];
            s2_res.frac = frac_sum[MANT_WIDTH-1:0];
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = s2_res;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign final_sign     = s2_q.sign;
    assign final_exponent = s2_q.exp;
    assign final_mantissa = s2_q.frac;
    assign result_is_zero = s2_q.zero;
    assign result_is_inf  = s2_q.inf;
    assign result_is_nan  = s2_q.nan;

endmodule

// File: tb/tb_fp32_norm_round.sv
// Scoreboard bench for fp32_norm_round: the driver pushes the expected result
// when a beat is accepted; a negedge monitor pops and compares on each output
// transfer, and also checks that outputs hold steady while stalled.
module tb_fp32_norm_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        in_is_nan = 1'b0;
    logic        in_is_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        final_sign;
    logic [7:0]  final_exponent;
    logic [22:0] final_mantissa;
    logic        result_is_zero;
    logic        result_is_inf;
    logic        result_is_nan;

    always #5 clk = ~clk;

    fp32_norm_round dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_is_nan      (in_is_nan),
        .in_is_inf      (in_is_inf),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .final_sign     (final_sign),
        .final_exponent (final_exponent),
        .final_mantissa (final_mantissa),
        .result_is_zero (result_is_zero),
        .result_is_inf  (result_is_inf),
        .result_is_nan  (result_is_nan)
    );

    // Result word: {sign, exp[7:0], frac[22:0], zero, inf, nan}
    logic [34:0] dut_word;
    assign dut_word = {final_sign, final_exponent, final_mantissa,
                       result_is_zero, result_is_inf, result_is_nan};

    logic [34:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 toggle, 3 stalled

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: find the leading one, keep 24 significant bits, round the
    // discarded remainder to nearest-even, then classify.
    function automatic logic [34:0] ref_model(input logic s, input logic [9:0] e_in,
                                              input logic [27:0] m_in, input logic n,
                                              input logic i);
        longint m, kept, rem, half;
        int     p, sh, e;
        logic   is_zero;
        logic [7:0]  ex;
        logic [22:0] fr;
        if (n) return {s, 8'd0, 23'd0, 3'b001};
        is_zero = (m_in == 28'd0);
        e = 0;
        kept = 0;
        if (!is_zero) begin
            m = longint'(m_in);
            p = 0;
            for (int b = 0; b < 28; b++) if (m_in[b]) p = b;
            e = int'($signed(e_in)) + p - 26;
            if (p > 23) begin
                sh   = p - 23;
                kept = m >> sh;
                rem  = m & ((longint'(1) << sh) - 1);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && (kept % 2) == 1)) kept++;
            end else begin
                kept = m << (23 - p);
            end
            if (kept == (longint'(1) << 24)) begin
                kept = kept >> 1;
                e++;
            end
        end
        if (i || (!is_zero && e >= 255)) return {s, 8'hFF, 23'd0, 3'b010};
        if (is_zero || e <= 0) return {s, 8'd0, 23'd0, 3'b100};
        ex = e[7:0];
        fr = kept[22:0];
        return {s, ex, fr, 3'b000};
    endfunction

    // out_ready pattern, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor
    logic        prev_stall = 1'b0;
    logic [34:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {34'd0, out_valid}, 35'd1);
                chk("stall_hold", dut_word, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", dut_word, 35'h7_FFFF_FFFF ^ dut_word);
                end else begin
                    chk("beat", dut_word, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = dut_word;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic n, input logic i,
                        input logic use_given, input logic [34:0] given);
        int waited = 0;
        in_sign = s; in_exp = e; in_mant = m; in_is_nan = n; in_is_inf = i;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(use_given ? given : ref_model(s, e, m, n, i));
                $display("send sign=%0d exp=%0d mant=%h nan=%0d inf=%0d",
                         s, $signed(e), m, n, i);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 200) begin
                chk("send_timeout", {34'd0, in_ready}, 35'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 35'(exp_q.size()), 35'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, {34'd0, out_valid}, 35'd0);
        chk({tag, "_outputs"}, dut_word, 35'd0);
        chk({tag, "_in_ready"}, {34'd0, in_ready}, 35'd1);
    endtask

    task automatic random_beat();
        logic [27:0] m;
        logic [9:0]  e;
        int          ev;
        if ($urandom_range(0, 3) == 0) begin
            e = 10'($urandom());
        end else begin
            ev = int'($urandom_range(0, 300)) - 20;
            e  = ev[9:0];
        end
        case ($urandom_range(0, 5))
            0:       m = 28'd0;
            1:       m = 28'($urandom() >> $urandom_range(4, 31));
            2:       m = 28'h4000000 | (28'($urandom()) & 28'h3FFFFF8) | 28'h4;
            default: m = 28'($urandom());
        endcase
        send(1'($urandom()), e, m, $urandom_range(0, 15) == 0,
             $urandom_range(0, 15) == 0, 1'b0, 35'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // directed cases with hand-derived results
        send(0, 10'd127, 28'h8000000, 0, 0, 1, {1'b0, 8'd128, 23'd0,   3'b000});
        send(0, 10'd127, 28'h4000004, 0, 0, 1, {1'b0, 8'd127, 23'd0,   3'b000});
        send(0, 10'd127, 28'h400000C, 0, 0, 1, {1'b0, 8'd127, 23'h2,   3'b000});
        send(0, 10'd127, 28'h7FFFFFC, 0, 0, 1, {1'b0, 8'd128, 23'd0,   3'b000});
        send(0, 10'd254, 28'h7FFFFFC, 0, 0, 1, {1'b0, 8'hFF,  23'd0,   3'b010});
        send(0, 10'd127, 28'h0000008, 0, 0, 1, {1'b0, 8'd104, 23'd0,   3'b000});
        send(1, 10'd20,  28'h0000008, 0, 0, 1, {1'b1, 8'd0,   23'd0,   3'b100});
        send(1, 10'd127, 28'h5A5A5A5, 1, 1, 1, {1'b1, 8'd0,   23'd0,   3'b001});
        send(0, 10'd300, 28'h0000000, 0, 0, 1, {1'b0, 8'd0,   23'd0,   3'b100});
        send(1, 10'd100, 28'h0000123, 0, 1, 1, {1'b1, 8'hFF,  23'd0,   3'b010});
        send(0, 10'd1,   28'h2000000, 0, 0, 1, {1'b0, 8'd0,   23'd0,   3'b100});
        send(0, 10'd2,   28'h2000000, 0, 0, 1, {1'b0, 8'd1,   23'd0,   3'b000});
        drain();

        // latency: accepted at edge A, visible after edge A+1
        send(0, 10'd130, 28'h6000000, 0, 0, 1, {1'b0, 8'd130, 23'h400000, 3'b000});
        @(negedge clk);
        chk("latency_early", {34'd0, out_valid}, 35'd0);
        @(negedge clk);
        chk("latency_on", {34'd0, out_valid}, 35'd1);
        @(posedge clk); #1;
        drain();

        // full pipe with consumer stalled blocks the input
        ready_mode = 3;
        @(posedge clk); #1;
        send(0, 10'd127, 28'h4000000, 0, 0, 0, 35'd0);
        send(1, 10'd127, 28'h4000010, 0, 0, 0, 35'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", {34'd0, in_ready}, 35'd0);
        chk("full_out_valid", {34'd0, out_valid}, 35'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // randomized traffic under random backpressure
        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            random_beat();
        end
        drain();

        // toggled backpressure with a reset pulse mid-stream
        ready_mode = 2;
        for (int k = 0; k < 4; k++) random_beat();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) random_beat();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
